// File: rtl/fp_pkg.sv
// ----------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the pipelined floating-point adder/subtractor.
//   - default field widths (exponent, mantissa, tag)
//   - operand class encoding (zero / normal / infinity / NaN)
//   - operand classifier and canonical quiet-NaN builder
//   - width-independent control structs carried by the pipeline stages
// No ports (package).
// ----------------------------------------------------------------------------
package fp_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_TAG_W = 4;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_e;

    // Control bits held alongside the stage-1 datapath registers.
    typedef struct packed {
        logic valid;
        logic special;   // result already resolved (NaN/Inf/zero operand)
        logic sign;      // sign of the larger-magnitude operand
        logic eff_sub;   // effective signs differ -> subtract magnitudes
    } fp_s1_ctrl_t;

    // Control bits held alongside the stage-2 datapath registers.
    typedef struct packed {
        logic valid;
        logic special;
        logic sign;
    } fp_s2_ctrl_t;

    // Subnormals (exp == 0) deliberately classify as zero.
    function automatic fp_class_e fp_classify(input logic exp_zero,
                                              input logic exp_ones,
                                              input logic man_zero);
        if (exp_zero)
            return CLS_ZERO;
        else if (exp_ones)
            return man_zero ? CLS_INF : CLS_NAN;
        else
            return CLS_NORM;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, only mantissa MSB set.
    // Returned zero-extended to 64 bits; callers slice to their width.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] r;
        r = ((64'd1 << exp_w) - 64'd1) << man_w;
        r = r | (64'd1 << (man_w - 1));
        return r;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// ----------------------------------------------------------------------------
// fp_lzc
// Parametrised leading-zero counter. Counts zeros from the MSB down to the
// first set bit; an all-zero input returns N.
// Ports:
//   in_i    [N-1:0]   value to scan
//   count_o [CW-1:0]  number of leading zeros, CW = $clog2(N+1)
// ----------------------------------------------------------------------------
module fp_lzc #(
    parameter int N  = 28,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  in_i,
    output logic [CW-1:0] count_o
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        count_o = CW'(N);
        for (int i = 0; i < N; i++) begin
            if (in_i[i])
                count_o = CW'(N - 1 - i);
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// ----------------------------------------------------------------------------
// fp_addsub_pipe
// Three-stage pipelined floating-point adder/subtractor with valid/ready
// handshake and global-stall backpressure.
//   stage 1: classify, resolve specials, order by magnitude, align smaller
//   stage 2: add/subtract significands, count leading zeros
//   stage 3: normalise, round, detect overflow/underflow, pack
// Build option: define FP_ADD_RNE_EN for round-to-nearest-even; otherwise
// the guard/round/sticky bits are discarded (truncation).
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake
//   in_a, in_b            operands {sign, exp, man}
//   in_op                 0 = A+B, 1 = A-B
//   in_tag                sideband tag, returned unchanged on out_tag
//   out_valid / out_ready result handshake
//   out_sum               result
//   out_ovf               result overflowed to +/-Inf
//   out_unf               nonzero result flushed to +/-0
// ----------------------------------------------------------------------------
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W,
    parameter int TAG_W = FP_TAG_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic                   in_op,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_sum,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   out_ovf,
    output logic                   out_unf
);

    localparam int FW   = 1 + EXP_W + MAN_W;
    localparam int SW   = MAN_W + 4;            // {hidden, man, G, R, S}
    localparam int SUMW = MAN_W + 5;            // SW plus carry
    localparam int AW   = 2 * MAN_W + 4;        // alignment shift window
    localparam int ZW   = $clog2(SUMW + 1);
    localparam int EW   = ((EXP_W > ZW) ? EXP_W : ZW) + 2;  // signed exponent
    localparam int RW   = MAN_W + 2;
    localparam logic [FW-1:0]    QNAN     = FW'(fp_qnan(EXP_W, MAN_W));
    localparam logic [EW-1:0]    EMAX     = EW'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
`ifdef FP_ADD_RNE_EN
    localparam logic RNE_EN = 1'b1;
`else
    localparam logic RNE_EN = 1'b0;
`endif

    logic en;

    // ---------------- stage 1: unpack / classify / align ----------------
    logic             sign_a, sign_b;
    logic [EXP_W-1:0] exp_a, exp_b, l_exp, s_exp, exp_diff;
    logic [MAN_W-1:0] man_a, man_b, l_man, s_man;
    fp_class_e        cls_a, cls_b;
    logic             swap, spec_d;
    logic [FW-1:0]    spec_val_d;
    logic [31:0]      shamt;
    logic [AW-1:0]    aligned;
    logic [SW-1:0]    l_sig_d, s_sig_d;

    assign sign_a = in_a[FW-1];
    assign exp_a  = in_a[FW-2 -: EXP_W];
    assign man_a  = in_a[MAN_W-1:0];
    assign sign_b = in_b[FW-1] ^ in_op;          // subtraction = add negated B
    assign exp_b  = in_b[FW-2 -: EXP_W];
    assign man_b  = in_b[MAN_W-1:0];
    assign cls_a  = fp_classify(exp_a == '0, exp_a == '1, man_a == '0);
    assign cls_b  = fp_classify(exp_b == '0, exp_b == '1, man_b == '0);

    always_comb begin
        spec_d     = 1'b1;
        spec_val_d = '0;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
            (cls_a == CLS_INF && cls_b == CLS_INF && sign_a != sign_b))
            spec_val_d = QNAN;
        else if (cls_a == CLS_INF)
            spec_val_d = {sign_a, exp_a, man_a};
        else if (cls_b == CLS_INF)
            spec_val_d = {sign_b, exp_b, man_b};
        else if (cls_a == CLS_ZERO && cls_b == CLS_ZERO)
            spec_val_d = {sign_a & sign_b, {(FW-1){1'b0}}};
        else if (cls_a == CLS_ZERO)
            spec_val_d = {sign_b, exp_b, man_b};
        else if (cls_b == CLS_ZERO)
            spec_val_d = {sign_a, exp_a, man_a};
        else
            spec_d = 1'b0;
    end

    assign swap     = {exp_b, man_b} > {exp_a, man_a};
    assign l_exp    = swap ? exp_b : exp_a;
    assign l_man    = swap ? man_b : man_a;
    assign s_exp    = swap ? exp_a : exp_b;
    assign s_man    = swap ? man_a : man_b;
    assign exp_diff = l_exp - s_exp;
    // Beyond MAN_W+3 the smaller operand only contributes to sticky.
    assign shamt    = (32'(exp_diff) > 32'(MAN_W + 3)) ? 32'(MAN_W + 3) : 32'(exp_diff);
    assign aligned  = {1'b1, s_man, {(MAN_W+3){1'b0}}} >> shamt;
    assign s_sig_d  = {aligned[AW-1 -: MAN_W+3], |aligned[MAN_W:0]};
    assign l_sig_d  = {1'b1, l_man, 3'b000};

    fp_s1_ctrl_t      s1_ctrl_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [SW-1:0]    s1_l_q, s1_s_q;
    logic [FW-1:0]    s1_spec_q;
    logic [TAG_W-1:0] s1_tag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_ctrl_q <= '0;
            s1_exp_q  <= '0;
            s1_l_q    <= '0;
            s1_s_q    <= '0;
            s1_spec_q <= '0;
            s1_tag_q  <= '0;
        end else if (en) begin
            s1_ctrl_q <= '{valid: in_valid, special: spec_d,
                           sign: swap ? sign_b : sign_a, eff_sub: sign_a ^ sign_b};
            s1_exp_q  <= l_exp;
            s1_l_q    <= l_sig_d;
            s1_s_q    <= s_sig_d;
            s1_spec_q <= spec_val_d;
            s1_tag_q  <= in_tag;
        end
    end

    // ---------------- stage 2: add / subtract, leading zeros ----------------
    logic [SUMW-1:0] sum_d;
    logic [ZW-1:0]   lzc_d;

    // |L| >= |S| so the difference never goes negative.
    assign sum_d = s1_ctrl_q.eff_sub ? ({1'b0, s1_l_q} - {1'b0, s1_s_q})
                                     : ({1'b0, s1_l_q} + {1'b0, s1_s_q});

    fp_lzc #(.N(SUMW), .CW(ZW)) u_lzc (
        .in_i    (sum_d),
        .count_o (lzc_d)
    );

    fp_s2_ctrl_t      s2_ctrl_q;
    logic [EXP_W-1:0] s2_exp_q;
    logic [SUMW-1:0]  s2_sum_q;
    logic [ZW-1:0]    s2_lzc_q;
    logic [FW-1:0]    s2_spec_q;
    logic [TAG_W-1:0] s2_tag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_ctrl_q <= '0;
            s2_exp_q  <= '0;
            s2_sum_q  <= '0;
            s2_lzc_q  <= '0;
            s2_spec_q <= '0;
            s2_tag_q  <= '0;
        end else if (en) begin
            s2_ctrl_q <= '{valid: s1_ctrl_q.valid, special: s1_ctrl_q.special,
                           sign: s1_ctrl_q.sign};
            s2_exp_q  <= s1_exp_q;
            s2_sum_q  <= sum_d;
            s2_lzc_q  <= lzc_d;
            s2_spec_q <= s1_spec_q;
            s2_tag_q  <= s1_tag_q;
        end
    end

    // ---------------- stage 3: normalise / round / pack ----------------
    logic [SW-1:0]    norm;
    logic [EW-1:0]    e_norm, e_fin;
    logic             round_up;
    logic [RW-1:0]    rnd;
    logic [MAN_W-1:0] man_fin;
    logic [FW-1:0]    res_d;
    logic             ovf_d, unf_d;

    always_comb begin
        // lzc counts the carry position too, so a clear carry means lzc >= 1
        // and the hidden bit is reached by shifting left lzc-1.
        if (s2_sum_q[SUMW-1]) begin
            norm   = {s2_sum_q[SUMW-1:2], s2_sum_q[1] | s2_sum_q[0]};
            e_norm = EW'(s2_exp_q) + EW'(1);
        end else begin
            norm   = s2_sum_q[SW-1:0] << (s2_lzc_q - 1'b1);
            e_norm = EW'(s2_exp_q) - EW'(s2_lzc_q) + EW'(1);
        end
        round_up = RNE_EN & norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd      = {1'b0, norm[SW-1:3]} + RW'(round_up);
        if (rnd[RW-1]) begin
            e_fin   = e_norm + EW'(1);
            man_fin = rnd[MAN_W:1];
        end else begin
            e_fin   = e_norm;
            man_fin = rnd[MAN_W-1:0];
        end

        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (s2_ctrl_q.special) begin
            res_d = s2_spec_q;
        end else if (s2_sum_q == '0) begin
            res_d = '0;                                   // exact cancellation
        end else if (!e_fin[EW-1] && e_fin >= EMAX) begin
            res_d = {s2_ctrl_q.sign, EXP_ONES, {MAN_W{1'b0}}};
            ovf_d = 1'b1;
        end else if (e_fin[EW-1] || e_fin == '0) begin
            res_d = {s2_ctrl_q.sign, {(FW-1){1'b0}}};
            unf_d = 1'b1;
        end else begin
            res_d = {s2_ctrl_q.sign, e_fin[EXP_W-1:0], man_fin};
        end
    end

    logic             out_valid_q, out_ovf_q, out_unf_q;
    logic [FW-1:0]    out_sum_q;
    logic [TAG_W-1:0] out_tag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_tag_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_unf_q   <= 1'b0;
        end else if (en) begin
            out_valid_q <= s2_ctrl_q.valid;
            out_sum_q   <= res_d;
            out_tag_q   <= s2_tag_q;
            out_ovf_q   <= ovf_d;
            out_unf_q   <= unf_d;
        end
    end

    // Whole pipe stalls together while the output is held; bubbles stay put.
    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_tag   = out_tag_q;
    assign out_ovf   = out_ovf_q;
    assign out_unf   = out_unf_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// ----------------------------------------------------------------------------
// tb_fp_addsub_pipe
// Self-checking bench for fp_addsub_pipe (default widths). Expected results
// are queued when operands are accepted and compared as results leave.
// Expectations that depend on rounding follow FP_ADD_RNE_EN.
// ----------------------------------------------------------------------------
module tb_fp_addsub_pipe;

    typedef struct packed {
        logic [31:0] sum;
        logic [3:0]  tag;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_op, out_valid, out_ready, out_ovf, out_unf;
    logic [31:0] in_a, in_b, out_sum;
    logic [3:0]  in_tag, out_tag;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   out_count = 0;

`ifdef FP_ADD_RNE_EN
    localparam logic [31:0] RND_UP_1 = 32'h3F800001;
    localparam logic [31:0] RND_UP_2 = 32'h40000000;
`else
    localparam logic [31:0] RND_UP_1 = 32'h3F800000;
    localparam logic [31:0] RND_UP_2 = 32'h3FFFFFFF;
`endif

    // Single-precision encodings of 1.0 .. 10.0
    logic [31:0] int_f [0:9] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                                 32'h40800000, 32'h40A00000, 32'h40C00000,
                                 32'h40E00000, 32'h41000000, 32'h41100000,
                                 32'h41200000};

    always #5 clk = ~clk;

    fp_addsub_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_tag   (out_tag),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    // Holds operands until accepted; returns at posedge+1.
    task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                            input logic [3:0] tag, input logic [31:0] sum,
                            input logic ovf, input logic unf);
        logic accepted;
        accepted = 1'b0;
        in_a = a; in_b = b; in_op = op; in_tag = tag; in_valid = 1'b1;
        for (int w = 0; w < 200 && !accepted; w++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                sb_q.push_back('{sum: sum, tag: tag, ovf: ovf, unf: unf});
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!accepted) begin
            errors++;
            $display("FAIL accept_timeout: tag=%0d in_ready=%b required 1", tag, in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int w = 0; w < 100 && sb_q.size() != 0; w++) @(posedge clk);
        #1;
    endtask

    // Scoreboard: pops and compares on every output transfer, and checks
    // that a stalled result stays put.
    task automatic monitor();
        exp_t        e;
        logic        prev_stall;
        logic [31:0] prev_sum;
        logic [3:0]  prev_tag;
        prev_stall = 1'b0; prev_sum = '0; prev_tag = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_sum !== prev_sum || out_tag !== prev_tag) begin
                        errors++;
                        $display("FAIL hold: valid=%b sum=%h tag=%0d required valid=1 sum=%h tag=%0d",
                                 out_valid, out_sum, out_tag, prev_sum, prev_tag);
                    end
                end
                if (out_valid && out_ready) begin
                    out_count++;
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: sum=%h tag=%0d required none", out_sum, out_tag);
                    end else begin
                        e = sb_q.pop_front();
                        if (out_sum !== e.sum || out_tag !== e.tag || out_ovf !== e.ovf || out_unf !== e.unf) begin
                            errors++;
                            $display("FAIL result: sum=%h tag=%0d ovf=%b unf=%b required sum=%h tag=%0d ovf=%b unf=%b",
                                     out_sum, out_tag, out_ovf, out_unf, e.sum, e.tag, e.ovf, e.unf);
                        end else begin
                            $display("out tag=%0d sum=%h ovf=%b unf=%b ok", out_tag, out_sum, out_ovf, out_unf);
                        end
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_sum   = out_sum;
                prev_tag   = out_tag;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", out_valid); end
        checks++; if (out_sum !== 32'h0) begin errors++; $display("FAIL rst_sum: got %h required 0", out_sum); end
        checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL rst_tag: got %h required 0", out_tag); end
        checks++; if (out_ovf !== 1'b0 || out_unf !== 1'b0) begin
            errors++; $display("FAIL rst_flags: got ovf=%b unf=%b required 0 0", out_ovf, out_unf);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_latency();
        in_a = 32'h40900000; in_b = 32'h40B9999A; in_op = 1'b0; in_tag = 4'd5; in_valid = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_ready: got %b required 1", in_ready); end
        sb_q.push_back('{sum: 32'h4124CCCD, tag: 4'd5, ovf: 1'b0, unf: 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_c1: out_valid=%b required 0", out_valid); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_c2: out_valid=%b required 0", out_valid); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_c3: out_valid=%b required 1", out_valid); end
        wait_drain();
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL lat_drain: pending=%0d required 0", sb_q.size()); end
    endtask

    task automatic test_vectors();
        drive_op(32'hC0900000, 32'h40B9999A, 1'b0, 4'd0, 32'h3FA66668, 1'b0, 1'b0);
        drive_op(32'h40900000, 32'h40B9999A, 1'b1, 4'd1, 32'hBFA66668, 1'b0, 1'b0);
        drive_op(32'h3F800000, 32'h33C00000, 1'b0, 4'd2, RND_UP_1,     1'b0, 1'b0);
        drive_op(32'h3F800000, 32'h33800000, 1'b0, 4'd3, 32'h3F800000, 1'b0, 1'b0);
        drive_op(32'h3FFFFFFF, 32'h33C00000, 1'b0, 4'd4, RND_UP_2,     1'b0, 1'b0);
        drive_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'd5, 32'h7F800000, 1'b1, 1'b0);
        drive_op(32'h7F000000, 32'h7F000000, 1'b0, 4'd6, 32'h7F800000, 1'b1, 1'b0);
        drive_op(32'h40900000, 32'h40900000, 1'b1, 4'd7, 32'h00000000, 1'b0, 1'b0);
        drive_op(32'h7F800000, 32'hFF800000, 1'b0, 4'd8, 32'h7FC00000, 1'b0, 1'b0);
        drive_op(32'h7F800000, 32'h7F800000, 1'b1, 4'd9, 32'h7FC00000, 1'b0, 1'b0);
        drive_op(32'h7F800001, 32'h3F800000, 1'b0, 4'd10, 32'h7FC00000, 1'b0, 1'b0);
        drive_op(32'hFF800000, 32'h3F800000, 1'b0, 4'd11, 32'hFF800000, 1'b0, 1'b0);
        drive_op(32'h00800001, 32'h00800000, 1'b1, 4'd12, 32'h00000000, 1'b0, 1'b1);
        drive_op(32'h80800001, 32'h00800000, 1'b0, 4'd13, 32'h80000000, 1'b0, 1'b1);
        drive_op(32'h00000000, 32'h40900000, 1'b1, 4'd14, 32'hC0900000, 1'b0, 1'b0);
        drive_op(32'h80000000, 32'h80000000, 1'b0, 4'd15, 32'h80000000, 1'b0, 1'b0);
        drive_op(32'h80000000, 32'h00000000, 1'b1, 4'd0, 32'h80000000, 1'b0, 1'b0);
        drive_op(32'h00000000, 32'h80000000, 1'b0, 4'd1, 32'h00000000, 1'b0, 1'b0);
        drive_op(32'h00400000, 32'h3F800000, 1'b0, 4'd2, 32'h3F800000, 1'b0, 1'b0);
        drive_op(32'h3F800000, 32'h3F800000, 1'b0, 4'd3, 32'h40000000, 1'b0, 1'b0);
        drive_op(32'h40400000, 32'hBF800000, 1'b0, 4'd4, 32'h40000000, 1'b0, 1'b0);
        drive_op(32'h3F800000, 32'h3F000000, 1'b1, 4'd5, 32'h3F000000, 1'b0, 1'b0);
        wait_drain();
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL vec_drain: pending=%0d required 0", sb_q.size()); end
    endtask

    task automatic test_back_to_back();
        int   start_cnt;
        logic ready_dropped;
        start_cnt     = out_count;
        ready_dropped = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    drive_op(int_f[i], int_f[0], 1'b0, 4'(i), int_f[i+1], 1'b0, 1'b0);
            end
            begin
                for (int cyc = 0; cyc < 30; cyc++) begin
                    out_ready = !(cyc >= 4 && cyc <= 7);
                    @(negedge clk);
                    if (!in_ready) ready_dropped = 1'b1;
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        checks++; if (ready_dropped !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_drop: got %b required 1", ready_dropped); end
        checks++; if (out_count - start_cnt != 8) begin
            errors++; $display("FAIL b2b_count: got %0d required 8", out_count - start_cnt);
        end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL b2b_drain: pending=%0d required 0", sb_q.size()); end
    endtask

    task automatic test_reset_in_flight();
        int start_cnt;
        start_cnt = out_count;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            drive_op(int_f[i], int_f[1], 1'b0, 4'(8 + i), int_f[i+2], 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flight_rst_async: out_valid=%b required 0", out_valid); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flight_rst_next: out_valid=%b required 0", out_valid); end
        sb_q.delete();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (out_count != start_cnt) begin
            errors++; $display("FAIL flight_emitted: got %0d outputs required 0", out_count - start_cnt);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flight_idle: out_valid=%b required 0", out_valid); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; in_tag = '0;
        out_ready = 1'b1;
        fork
            monitor();
        join_none
        test_reset();
        test_latency();
        test_vectors();
        test_back_to_back();
        test_reset_in_flight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
